// File: rtl/wc_frame_driver_if.sv
// D/Z link between the host-side frame driver and the Winograd core,
// with the host stream handshakes.
interface wc_frame_driver_if #(
  parameter int unsigned N  = 10,
  parameter int unsigned DW = 7,
  parameter int unsigned ZW = 4
);
  logic [DW-1:0]   in_data;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] D;
  logic            d_valid;
  logic [N*ZW-1:0] Z;
  logic [ZW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic            busy;

  // Frame driver side
  modport master (
    input  in_data, in_valid, Z, out_ready,
    output in_ready, D, d_valid, out_data, out_valid, busy
  );

  // Host / core side
  modport slave (
    output in_data, in_valid, Z, out_ready,
    input  in_ready, D, d_valid, out_data, out_valid, busy
  );
endinterface

// File: rtl/wc_frame_driver.sv
// Packs N input elements into one D frame for the Winograd core, captures the
// Z result LAT cycles after issue and streams it back one element at a time.
// Only one frame is ever in flight.
module wc_frame_driver #(
  parameter int unsigned N   = 10,
  parameter int unsigned DW  = 7,
  parameter int unsigned ZW  = 4,
  parameter int unsigned LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  wc_frame_driver_if.master bus
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t          r_state;
  logic [DW-1:0]   r_slots [N];
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   r_odx;
  logic [CW-1:0]   r_wcnt;
  logic [N*ZW-1:0] r_z;
  logic [N*DW-1:0] r_d;
  logic            r_d_valid;
  logic            r_in_ready;
  logic [ZW-1:0]   r_out_data;
  logic            r_out_valid;
  logic            r_busy;

  logic            w_accept;
  logic            w_hs;
  logic            w_last_in;
  logic            w_last_out;
  logic            w_capture;
  logic [IW-1:0]   w_next_odx;
  logic [N*DW-1:0] w_frame;

  assign w_accept   = bus.in_valid && r_in_ready;
  assign w_hs       = r_out_valid && bus.out_ready;
  assign w_last_in  = (r_idx == IW'(N - 1));
  assign w_last_out = (r_odx == IW'(N - 1));
  assign w_next_odx = r_odx + IW'(1);
  // Capture edge is LAT edges after the ISSUE cycle began; LAT=1 captures leaving ISSUE
  assign w_capture  = ((r_state == S_ISSUE) && (LAT == 1)) ||
                      ((r_state == S_WAIT) && (r_wcnt == CW'(LAT - 1)));

  // Frame as it will look once the element arriving now fills the last slot
  always_comb begin
    w_frame = '0;
    for (int unsigned k = 0; k < N - 1; k++) begin
      w_frame[k*DW +: DW] = r_slots[k];
    end
    w_frame[(N-1)*DW +: DW] = bus.in_data;
  end

  // Fill / issue / wait / drain sequencing with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FILL;
      r_idx       <= '0;
      r_odx       <= '0;
      r_wcnt      <= '0;
      r_z         <= '0;
      r_d         <= '0;
      r_d_valid   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
        r_slots[k] <= '0;
      end
    end else begin
      r_d_valid <= 1'b0;
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            r_slots[r_idx] <= bus.in_data;
            r_busy         <= 1'b1;
            if (w_last_in) begin
              r_idx      <= '0;
              r_d        <= w_frame;
              r_d_valid  <= 1'b1;
              r_in_ready <= 1'b0;
              r_state    <= S_ISSUE;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end

        S_ISSUE, S_WAIT: begin
          if (w_capture) begin
            r_z         <= bus.Z;
            r_out_data  <= bus.Z[ZW-1:0];
            r_out_valid <= 1'b1;
            r_odx       <= '0;
            r_state     <= S_DRAIN;
          end else if (r_state == S_ISSUE) begin
            r_wcnt  <= CW'(1);
            r_state <= S_WAIT;
          end else begin
            r_wcnt <= r_wcnt + CW'(1);
          end
        end

        S_DRAIN: begin
          if (w_hs) begin
            if (w_last_out) begin
              r_out_valid <= 1'b0;
              r_odx       <= '0;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= S_FILL;
            end else begin
              r_odx      <= w_next_odx;
              r_out_data <= r_z[w_next_odx*ZW +: ZW];
            end
          end
        end

        default: begin
          r_state <= S_FILL;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.D         = r_d;
  assign bus.d_valid   = r_d_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_wc_frame_driver.sv
// Bench for wc_frame_driver: transaction-level reference model (queues of
// pending input elements and results, age of the frame in flight) compared
// against the DUT every cycle, plus literal checks on known frames.
module tb_wc_frame_driver;

  localparam int N     = 10;
  localparam int DW    = 7;
  localparam int ZW    = 4;
  localparam int LAT   = 4;
  localparam int DALL  = N * DW;
  localparam int ZALL  = N * ZW;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  wc_frame_driver_if #(.N(N), .DW(DW), .ZW(ZW)) bus ();

  wc_frame_driver #(.N(N), .DW(DW), .ZW(ZW), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks;
  int errors;
  int cyc;

  // Reference model
  logic [DW-1:0]   m_fill [$];
  logic [ZW-1:0]   m_res  [$];
  int              m_age;
  logic [DALL-1:0] m_D;
  bit              m_live;
  bit              g_acc;

  // Observation logs for literal checks
  logic [ZW-1:0]   hs_log [$];
  int              dv_cyc [$];
  logic [DALL-1:0] dv_D   [$];

  bit              use_fixed;
  logic [ZALL-1:0] fixed_z;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: compare outputs with the model, drive inputs, advance model
  task automatic step(input bit r, input bit iv, input logic [DW-1:0] id, input bit ordy);
    logic [ZALL-1:0] z;
    bit e_ir;
    @(negedge clk);
    cyc++;
    e_ir = (m_age < 0) && (m_res.size() == 0);
    if (m_live) begin
      check_bit("in_ready", bus.in_ready, e_ir);
      check_bit("d_valid", bus.d_valid, m_age == 0);
      check_vec("D", 128'(bus.D), 128'(m_D));
      check_bit("out_valid", bus.out_valid, m_res.size() != 0);
      if (m_res.size() != 0) check_vec("out_data", 128'(bus.out_data), 128'(m_res[0]));
      check_bit("busy", bus.busy, !(e_ir && (m_fill.size() == 0)));
    end
    if (bus.d_valid === 1'b1) begin
      dv_cyc.push_back(cyc);
      dv_D.push_back(bus.D);
    end
    if ((bus.out_valid === 1'b1) && ordy) hs_log.push_back(bus.out_data);

    z = ZALL'({$urandom, $urandom});
    if (use_fixed && (m_age == LAT - 1)) z = fixed_z;
    rst           = r;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    bus.Z         = z;

    g_acc = 1'b0;
    if (r) begin
      m_fill.delete();
      m_res.delete();
      m_age  = -1;
      m_D    = '0;
      m_live = 1'b1;
    end else if (m_live) begin
      if ((m_res.size() != 0) && ordy) void'(m_res.pop_front());
      if (m_age >= 0) begin
        m_age++;
        if (m_age == LAT) begin
          m_age = -1;
          for (int k = 0; k < N; k++) m_res.push_back(z[k*ZW +: ZW]);
        end
      end
      if (e_ir && iv) begin
        g_acc = 1'b1;
        m_fill.push_back(id);
        if (m_fill.size() == N) begin
          for (int k = 0; k < N; k++) m_D[k*DW +: DW] = m_fill[k];
          m_fill.delete();
          m_age = 0;
        end
      end
    end
  endtask

  task automatic clear_logs();
    hs_log.delete();
    dv_cyc.delete();
    dv_D.delete();
  endtask

  task automatic check_reset_state(input string tag);
    @(posedge clk);
    #1;
    check_bit({tag, "_in_ready"}, bus.in_ready, 1'b1);
    check_bit({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check_bit({tag, "_d_valid"}, bus.d_valid, 1'b0);
    check_bit({tag, "_busy"}, bus.busy, 1'b0);
    check_vec({tag, "_D"}, 128'(bus.D), 128'(0));
  endtask

  initial begin
    int cnt;
    logic [DALL-1:0] dv;
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    m_age     = -1;
    m_D       = '0;
    m_live    = 1'b0;
    use_fixed = 1'b0;
    fixed_z   = '0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.Z         = '0;

    // Reset state
    step(1, 0, '0, 0);
    step(1, 0, '0, 0);
    check_reset_state("reset");

    // Frame 0..9 with a known Z at the capture edge
    use_fixed = 1'b1;
    fixed_z   = 40'h0123456789;
    clear_logs();
    for (int i = 0; i < N; i++) step(0, 1, DW'(i), 1);
    for (int i = 0; i < 30; i++) step(0, 0, '0, 1);
    check_int("t1_dvalid_pulses", dv_cyc.size(), 1);
    if (dv_D.size() > 0) begin
      dv = dv_D[0];
      for (int k = 0; k < N; k++) check_vec("t1_D_slot", 128'(dv[k*DW +: DW]), 128'(k));
    end
    check_int("t2_hs_count", hs_log.size(), 10);
    for (int i = 0; i < hs_log.size() && i < N; i++)
      check_vec("t2_out_seq", 128'(hs_log[i]), 128'(9 - i));

    // Drain with out_ready pattern 1,0,0,1,0,0...
    fixed_z = 40'hFEDCBA9876;
    clear_logs();
    for (int i = 0; i < N; i++) step(0, 1, DW'(i + 20), 1);
    for (int j = 0; j < 60; j++) step(0, 0, '0, (j % 3) == 0);
    check_int("t3_hs_count", hs_log.size(), 10);
    for (int i = 0; i < hs_log.size() && i < N; i++)
      check_vec("t3_out_seq", 128'(hs_log[i]), 128'(6 + i));
    use_fixed = 1'b0;

    // in_valid held high, out_ready tied high: back-to-back frames
    clear_logs();
    cnt = 0;
    for (int j = 0; j < 60; j++) begin
      step(0, 1, DW'(cnt), 1);
      if (g_acc) cnt++;
    end
    check_bit("t6_two_frames", dv_cyc.size() >= 2, 1'b1);
    if (dv_cyc.size() >= 2) begin
      check_int("t6_period", dv_cyc[1] - dv_cyc[0], 2 * N + LAT);
      dv = dv_D[0];
      check_vec("t4_f0_slot0", 128'(dv[0 +: DW]), 128'(0));
      check_vec("t4_f0_slot9", 128'(dv[9*DW +: DW]), 128'(9));
      dv = dv_D[1];
      check_vec("t4_f1_slot0", 128'(dv[0 +: DW]), 128'(10));
      check_vec("t4_f1_slot9", 128'(dv[9*DW +: DW]), 128'(19));
    end

    // Reset after 5 accepts (a frame was issued earlier, so D is nonzero here)
    for (int j = 0; j < 40; j++) step(0, 0, '0, 1);
    for (int i = 0; i < 5; i++) step(0, 1, DW'(i + 50), 1);
    step(1, 1, '0, 1);
    check_reset_state("rst_partial");

    // Reset mid-drain
    for (int i = 0; i < N; i++) step(0, 1, DW'(i + 30), 0);
    begin
      int t;
      for (t = 0; t < 20 && (bus.out_valid !== 1'b1); t++) step(0, 0, '0, 0);
      if (bus.out_valid !== 1'b1) check_bit("t5_drain_timeout", bus.out_valid, 1'b1);
    end
    for (int i = 0; i < 3; i++) step(0, 0, '0, 1);
    step(1, 0, '0, 1);
    check_reset_state("rst_drain");

    // Following frame packs from slot 0
    clear_logs();
    for (int i = 0; i < N; i++) step(0, 1, DW'(64 + i), 1);
    for (int i = 0; i < 30; i++) step(0, 0, '0, 1);
    check_int("t5_dvalid_pulses", dv_cyc.size(), 1);
    if (dv_D.size() > 0) begin
      dv = dv_D[0];
      for (int k = 0; k < N; k++) check_vec("t5_D_slot", 128'(dv[k*DW +: DW]), 128'(64 + k));
    end
    check_int("t5_hs_count", hs_log.size(), 10);

    // Randomised traffic with occasional resets
    for (int j = 0; j < 3000; j++) begin
      bit r;
      bit iv;
      bit ordy;
      r    = ($urandom_range(0, 299) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = (j >= 1500) ? 1'b1 : ($urandom_range(0, 2) != 0);
      step(r, iv, DW'($urandom), ordy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
